// File: rtl/softmax_normalizer.sv
// rtl/softmax_normalizer.sv - collects a frame of minifloat e^x values and streams each divided by the frame sum
//
// Purpose: final stage of the 8-bit softmax datapath. Minifloat format is
// 1 sign / 4 exponent / 3 mantissa, bias 7, exponent 0 means zero.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     input handshake, in_ready high only while collecting
//   in_data               e^x element (non-negative minifloat)
//   out_valid/out_ready   output handshake
//   out_data              e^x_i / sum (minifloat)
//   out_index             class index i of out_data
//   busy                  high while dividing or presenting a result
//   done                  one-cycle pulse after the last element of a frame leaves
module softmax_normalizer #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [IDX_W-1:0]      out_index,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {S_COLLECT, S_DIV, S_OUT} state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  // Non-negative minifloat add, magnitudes only, truncating, saturating to
  // the largest finite value.
  function automatic logic [6:0] fadd(input logic [6:0] a, input logic [6:0] b);
    logic [6:0] hi, lo, res;
    logic [3:0] d;
    logic [4:0] m, e;
    res = '0;
    if (a[6:3] == 4'd0) begin
      res = b;
    end else if (b[6:3] == 4'd0) begin
      res = a;
    end else begin
      if (a[6:3] >= b[6:3]) begin
        hi = a;
        lo = b;
      end else begin
        hi = b;
        lo = a;
      end
      d = hi[6:3] - lo[6:3];
      m = {2'b01, hi[2:0]} + ({2'b01, lo[2:0]} >> d);
      if (m[4]) begin
        e   = {1'b0, hi[6:3]} + 5'd1;
        res = (e > 5'd15) ? 7'h7F : {e[3:0], m[3:1]};
      end else begin
        res = {hi[6:3], m[2:0]};
      end
    end
    return res;
  endfunction

  state_e           state_q, state_d;
  logic [IDX_W-1:0] count_q, count_d;
  logic [6:0]       sum_q, sum_d;
  logic [2:0]       cyc_q, cyc_d;
  logic [4:0]       r_q, r_d;
  logic [3:0]       q_q, q_d;
  logic [6:0]       out_data_q, out_data_d;
  logic             done_q, done_d;

  // The sign bit is dropped on entry: a (never expected) negative input is
  // treated as zero rather than poisoning the sum.
  logic [6:0] mem_q [NUM_CLASSES];
  logic [6:0] in_clean;
  assign in_clean = in_data[7] ? 7'h00 : in_data[6:0];

  // Divider datapath: operands come straight from the buffer and sum, which
  // are frozen outside COLLECT, so only the partial remainder is registered.
  logic [6:0]        x_op;
  logic [3:0]        ex, es, ms;
  logic [4:0]        r_cur, r_rem;
  logic              div_bit;
  logic [4:0]        qbits;
  logic signed [6:0] e_raw;
  logic [2:0]        mant;
  logic [6:0]        div_result;

  assign x_op = mem_q[count_q];
  assign ex   = x_op[6:3];
  assign es   = sum_q[6:3];
  assign ms   = {1'b1, sum_q[2:0]};

  always_comb begin
    r_cur      = (cyc_q == 3'd0) ? {2'b01, x_op[2:0]} : r_q;
    div_bit    = (r_cur >= {1'b0, ms});
    r_rem      = div_bit ? (r_cur - {1'b0, ms}) : r_cur;
    qbits      = {q_q, div_bit};
    // b0 set means the quotient is >= 1.0, so the leading one is b0 itself.
    e_raw      = $signed({3'b000, ex}) - $signed({3'b000, es}) + (qbits[4] ? 7'sd7 : 7'sd6);
    mant       = qbits[4] ? qbits[3:1] : qbits[2:0];
    div_result = '0;
    if (ex == 4'd0 || es == 4'd0 || e_raw < 7'sd1) begin
      div_result = 7'h00;
    end else if (e_raw > 7'sd15) begin
      div_result = 7'h7F;
    end else begin
      div_result = {e_raw[3:0], mant};
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    sum_d      = sum_q;
    cyc_d      = cyc_q;
    r_d        = r_q;
    q_d        = q_q;
    out_data_d = out_data_q;
    done_d     = 1'b0;
    case (state_q)
      S_COLLECT: begin
        if (in_valid) begin
          sum_d = fadd(sum_q, in_clean);
          if (count_q == LAST_IDX) begin
            count_d = '0;
            cyc_d   = 3'd0;
            state_d = S_DIV;
          end else begin
            count_d = count_q + IDX_W'(1);
          end
        end
      end
      S_DIV: begin
        r_d   = r_rem << 1;
        q_d   = qbits[3:0];
        cyc_d = cyc_q + 3'd1;
        if (cyc_q == 3'd4) begin
          out_data_d = div_result;
          cyc_d      = 3'd0;
          state_d    = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          if (count_q == LAST_IDX) begin
            done_d  = 1'b1;
            count_d = '0;
            sum_d   = '0;
            state_d = S_COLLECT;
          end else begin
            count_d = count_q + IDX_W'(1);
            cyc_d   = 3'd0;
            state_d = S_DIV;
          end
        end
      end
      default: state_d = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_COLLECT;
      count_q    <= '0;
      sum_q      <= '0;
      cyc_q      <= '0;
      r_q        <= '0;
      q_q        <= '0;
      out_data_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      sum_q      <= sum_d;
      cyc_q      <= cyc_d;
      r_q        <= r_d;
      q_q        <= q_d;
      out_data_q <= out_data_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_COLLECT && in_valid) begin
      mem_q[count_q] <= in_clean;
    end
  end

  assign in_ready  = (state_q == S_COLLECT);
  assign out_valid = (state_q == S_OUT);
  assign busy      = (state_q == S_DIV) || (state_q == S_OUT);
  assign out_data  = {1'b0, out_data_q};
  assign out_index = count_q;
  assign done      = done_q;

endmodule

// File: tb/tb_softmax_normalizer.sv
// tb/tb_softmax_normalizer.sv - directed vector bench for softmax_normalizer
module tb_softmax_normalizer;
  localparam int NC = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_data;
  logic [IW-1:0] out_index;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  softmax_normalizer #(.DATA_WIDTH(8), .NUM_CLASSES(NC), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [3:0][7:0] din;
    logic [3:0][7:0] dout;
    logic            junk;
  } vec_t;

  vec_t vecs[7];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic vec_t mk(input logic [7:0] i0, i1, i2, i3,
                              input logic [7:0] o0, o1, o2, o3,
                              input logic junk);
    vec_t v;
    v.din  = {i3, i2, i1, i0};
    v.dout = {o3, o2, o1, o0};
    v.junk = junk;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic send(input logic [7:0] d);
    int t = 0;
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("in_ready_wait", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  // Called at the negedge following the previous transfer edge. With that
  // transfer cycle as cycle 0, out_valid must appear in cycle 6, i.e. 5
  // negedges later.
  task automatic take(input logic [7:0] ed, input int ei, input int hold, input logic elast);
    int n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("gap_cycles", n, 5);
    chk("out_data", out_data, ed);
    chk("out_index", out_index, ei);
    chk("busy_out", busy, 1);
    chk("in_ready_out", in_ready, 0);
    chk("done_early", done, 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, ed);
      chk("stall_index", out_index, ei);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_drop", out_valid, 0);
    chk("done", done, elast);
    chk("in_ready_after", in_ready, elast);
    chk("busy_after", busy, !elast);
  endtask

  task automatic run_vec(input vec_t v);
    for (int i = 0; i < NC; i++) send(v.din[i]);
    if (v.junk) begin
      in_valid = 1'b1;
      in_data  = 8'h40;
    end
    for (int i = 0; i < NC; i++) begin
      if (i == NC - 1) in_valid = 1'b0;
      take(v.dout[i], i, 0, (i == NC - 1));
    end
    @(negedge clk);
    chk("done_once", done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = mk(8'h38, 8'h38, 8'h38, 8'h38, 8'h28, 8'h28, 8'h28, 8'h28, 1'b0);
    vecs[1] = mk(8'h38, 8'h38, 8'h40, 8'h00, 8'h28, 8'h28, 8'h30, 8'h00, 1'b0);
    vecs[2] = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    vecs[3] = mk(8'h38, 8'h40, 8'h44, 8'h48, 8'h1C, 8'h24, 8'h29, 8'h2C, 1'b0);
    vecs[4] = mk(8'h08, 8'h78, 8'h00, 8'h00, 8'h00, 8'h38, 8'h00, 8'h00, 1'b0);
    vecs[5] = mk(8'h78, 8'h78, 8'h00, 8'h00, 8'h30, 8'h30, 8'h00, 8'h00, 1'b0);
    vecs[6] = mk(8'h38, 8'h38, 8'h38, 8'h38, 8'h28, 8'h28, 8'h28, 8'h28, 1'b1);

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 7; k++) run_vec(vecs[k]);

    // Backpressure: index 1 held for 3 extra cycles.
    for (int i = 0; i < NC; i++) send(8'h38);
    take(8'h28, 0, 0, 1'b0);
    take(8'h28, 1, 3, 1'b0);
    take(8'h28, 2, 0, 1'b0);
    take(8'h28, 3, 0, 1'b1);
    @(negedge clk);

    // Reset asserted in the third DIV cycle of index 2.
    for (int i = 0; i < NC; i++) send(8'h38);
    take(8'h28, 0, 0, 1'b0);
    take(8'h28, 1, 0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_done", done, 0);
    chk("midrst_out_index", out_index, 0);
    chk("midrst_out_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("postrst_quiet", {out_valid, done}, 2'b00);
    end
    run_vec(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/softmax_normalizer.md
Name: softmax_normalizer

Overview:
- Downstream consumer of the per-class exponent units in the 8-bit softmax datapath.
- Collects NUM_CLASSES minifloat e^x values and accumulates their sum as they arrive.
- Then divides each stored value by the sum and streams out the normalized probabilities in class order.
- Number format throughout: 8-bit minifloat = 1 sign, 4 exponent, 3 mantissa, bias 7. 1.0 = 0x38. Exponent field 0 means zero (no denormals).

Parameters:
- DATA_WIDTH, 8, element width; only 8 is supported.
- NUM_CLASSES, 10, elements per frame.
- IDX_W, $clog2(NUM_CLASSES), width of the index output.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  one element offered on in_data.
- in_ready  output  1  high while in COLLECT; transfer = in_valid & in_ready.
- in_data  input  8  exponent value (always non-negative).
- out_valid  output  1  normalized element available.
- out_ready  input  1  downstream accepts; transfer = out_valid & out_ready.
- out_data  output  8  e^x_i / sum, minifloat.
- out_index  output  IDX_W  class index i of out_data.
- busy  output  1  high in DIV and OUT states.
- done  output  1  one-cycle pulse after the last element transfers.

Behaviour:
- Reset (async, rst_n=0):
  - state=COLLECT, count=0, sum=0x00.
  - out_valid=0, out_data=0x00, out_index=0, done=0, busy=0.
  - Buffer contents are don't-care.
- COLLECT:
  - in_ready=1.
  - On each transfer: buf[count] <= in_data; sum <= floatAdd(sum, in_data) using the existing combinational adder; count++.
  - On the transfer with count==NUM_CLASSES-1: go to DIV, count <= 0.
  - in_valid is ignored in every other state (in_ready=0).
- DIV (5 cycles per element):
  - Cycle 0 loads operands: x=buf[count], s=sum.
  - If x exponent==0 or s exponent==0, the result is 0x00 and the iteration is skipped (the DIV stay is still 5 cycles).
  - Otherwise mx={1,x.mant}, ms={1,s.mant}, r=mx.
  - Restoring division, one bit per cycle, 5 bits b0..b4: bit = (r>=ms); if set, r -= ms; then r <<= 1.
  - Normalization:
    - If b0=1: mant=b1b2b3, e = ex-es+7.
    - Else: mant=b2b3b4, e = ex-es+6.
  - Truncate; no rounding.
  - Sign is always 0.
  - e<1 gives 0x00. e>15 saturates to 0x7F.
  - Go to OUT.
- OUT:
  - out_valid=1, out_data=result, out_index=count.
  - out_data and out_index stay stable while out_ready=0.
  - On transfer:
    - If count==NUM_CLASSES-1: done=1 for one cycle, count=0, sum=0x00, state COLLECT.
    - Else: count++, state DIV.
  - out_valid drops the cycle after transfer.
- Latency and throughput:
  - First out_valid rises 6 cycles after the last input transfer.
  - Per-element throughput with out_ready held high: 1 element per 6 cycles.
- Simultaneous events: done and in_ready both assert in the cycle after the final output transfer; an input in that cycle is accepted as element 0 of the next frame.
- Reset mid-operation: immediate return to reset values; the partial frame is discarded, and no done or out_valid pulse is produced.
- All registers update only on posedge clk, except for the async reset.

Test Plan:
- NUM_CLASSES=4; inputs 0x38,0x38,0x38,0x38 -> sum 0x48; outputs 0x28 (0.25) at indices 0..3; done pulses once, 1 cycle after index 3.
- Inputs 0x38,0x38,0x40,0x00 -> sum 0x48; outputs 0x28,0x28,0x30,0x00 in order.
- All four inputs 0x00 -> outputs 0x00 x4; done asserts; no X on out_data.
- out_ready held low 3 cycles during index 1 -> out_valid stays 1; out_data/out_index unchanged; index 2 only follows the ready transfer.
- in_valid held high with data 0x40 during DIV/OUT -> in_ready=0; buffer and sum unaffected; outputs match the first scenario.
- rst_n pulsed low in the 3rd DIV cycle of index 2 -> out_valid=0, busy=0, in_ready=1 immediately; a fresh frame then reproduces the first scenario exactly.
